// File: rtl/sync_fifo_if.sv
// Producer/consumer handshake bundle for sync_fifo.
// The master side drives requests and write data; the slave side returns status and read data.
interface sync_fifo_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] DataInput;
  logic                  full;
  logic                  empty;
  logic [DATA_WIDTH-1:0] DataOutput;

  modport master (
    output push, pop, DataInput,
    input  full, empty, DataOutput
  );

  modport slave (
    input  push, pop, DataInput,
    output full, empty, DataOutput
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered read port, occupancy-count flags and
// explicit pointer wrap so that any depth >= 2 works.
module sync_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int MEM_DEPTH  = 8
) (
  input  logic         clk,
  input  logic         reset,
  sync_fifo_if.slave   bus
);
  localparam int PTR_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CNT_W = $clog2(MEM_DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  push_ok;
  logic                  pop_ok;

  // Compare against the last index rather than relying on natural overflow.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MEM_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign bus.empty      = (count == '0);
  assign bus.full       = (count == CNT_W'(MEM_DEPTH));
  assign bus.DataOutput = data_out;

  assign push_ok = bus.push & ~bus.full;
  assign pop_ok  = bus.pop  & ~bus.empty;

  // Storage is never cleared; the write is gated by reset so a push during
  // reset has no effect.
  always_ff @(posedge clk) begin
    if (reset && push_ok) begin
      mem[wr_ptr] <= bus.DataInput;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      data_out <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop_ok) begin
        rd_ptr   <= ptr_inc(rd_ptr);
        data_out <= mem[rd_ptr];
      end
      if (push_ok && !pop_ok) begin
        count <= count + 1'b1;
      end else if (pop_ok && !push_ok) begin
        count <= count - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: reset, fill/drain, wrap-around, simultaneous
// push/pop corner cases and mid-operation reset, against hand-computed values.
module tb_sync_fifo;
  localparam int DW = 16;
  localparam int DEPTH = 8;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  sync_fifo_if #(.DATA_WIDTH(DW)) bus ();

  sync_fifo #(.DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Apply inputs for one clock, then settle just after the edge for sampling.
  task automatic step(input logic ps, input logic pp, input logic [DW-1:0] d);
    bus.push      = ps;
    bus.pop       = pp;
    bus.DataInput = d;
    @(posedge clk);
    #1;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
  endtask

  task automatic check_flags(input string tag, input logic e, input logic f);
    check_eq({tag, "_empty"}, 32'(bus.empty), 32'(e));
    check_eq({tag, "_full"},  32'(bus.full),  32'(f));
  endtask

  logic [DW-1:0] fill_vals [8] = '{16, 5, 4, 3, 2, 1, 2, 3};
  logic [DW-1:0] wrap_vals [8] = '{1, 3, 5, 7, 9, 10, 11, 12};

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    reset         = 1'b0;
    bus.push      = 1'b0;
    bus.pop       = 1'b0;
    bus.DataInput = '0;

    // Reset with push/pop requested: must have no effect.
    step(1'b1, 1'b1, 16'd77);
    check_flags("rst", 1'b1, 1'b0);
    check_eq("rst_dout", 32'(bus.DataOutput), 32'd0);
    reset = 1'b1;
    step(1'b0, 1'b0, '0);
    check_flags("rst_rel", 1'b1, 1'b0);
    check_eq("rst_rel_dout", 32'(bus.DataOutput), 32'd0);

    // Fill: four back-to-back, then four separated by idle cycles.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, fill_vals[i]);
      check_flags($sformatf("fill%0d", i), 1'b0, (i == 7));
      if (i >= 4 && i < 7) step(1'b0, 1'b0, '0);
    end
    step(1'b1, 1'b0, 16'd99);
    check_flags("overflow", 1'b0, 1'b1);

    // Drain: four back-to-back pops, then pop/idle alternating.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, '0);
      check_eq($sformatf("drain%0d", i), 32'(bus.DataOutput), 32'(fill_vals[i]));
      check_flags($sformatf("drain%0d", i), (i == 7), 1'b0);
      if (i >= 4) step(1'b0, 1'b0, '0);
    end
    step(1'b0, 1'b1, '0);
    check_eq("underflow_dout", 32'(bus.DataOutput), 32'd3);
    check_flags("underflow", 1'b1, 1'b0);

    // Wrap-around pass.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, wrap_vals[i]);
      check_flags($sformatf("wfill%0d", i), 1'b0, (i == 7));
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, '0);
      check_eq($sformatf("wdrain%0d", i), 32'(bus.DataOutput), 32'(wrap_vals[i]));
      check_flags($sformatf("wdrain%0d", i), (i == 7), 1'b0);
    end

    // Simultaneous push/pop with 3 stored: head comes out, occupancy stays 3.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, DW'(100 + i));
    step(1'b1, 1'b1, 16'd103);
    check_eq("sim_mid_dout", 32'(bus.DataOutput), 32'd100);
    check_flags("sim_mid", 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, '0);
      check_eq($sformatf("sim_mid_pop%0d", i), 32'(bus.DataOutput), 32'(101 + i));
    end
    check_flags("sim_mid_end", 1'b1, 1'b0);

    // Simultaneous while empty: only the push lands, no read-through.
    step(1'b1, 1'b1, 16'd200);
    check_eq("sim_empty_dout", 32'(bus.DataOutput), 32'd103);
    check_flags("sim_empty", 1'b0, 1'b0);
    step(1'b0, 1'b1, '0);
    check_eq("sim_empty_pop", 32'(bus.DataOutput), 32'd200);
    check_flags("sim_empty_end", 1'b1, 1'b0);

    // Simultaneous while full: only the pop lands, push data dropped.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, DW'(i + 1));
    check_flags("sim_full_pre", 1'b0, 1'b1);
    step(1'b1, 1'b1, 16'd55);
    check_eq("sim_full_dout", 32'(bus.DataOutput), 32'd1);
    check_flags("sim_full", 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b1, '0);
      check_eq($sformatf("sim_full_pop%0d", i), 32'(bus.DataOutput), 32'(i + 2));
    end
    check_flags("sim_full_end", 1'b1, 1'b0);

    // Reset mid-operation with 5 stored discards everything.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'(10 + i));
    reset = 1'b0;
    step(1'b0, 1'b0, '0);
    reset = 1'b1;
    check_flags("mid_rst", 1'b1, 1'b0);
    check_eq("mid_rst_dout", 32'(bus.DataOutput), 32'd0);
    step(1'b1, 1'b0, 16'd42);
    check_flags("post_rst_push", 1'b0, 1'b0);
    step(1'b0, 1'b1, '0);
    check_eq("post_rst_pop", 32'(bus.DataOutput), 32'd42);
    check_flags("post_rst_end", 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
